// File: rtl/axi_spy_pkg.sv
// Shared types for the AXI spy drain controller: channel ids and drain FSM states.
package axi_spy_pkg;

    localparam int NUM_SPY_CH = 4;

    typedef enum logic [1:0] {
        CH_AR = 2'd0,
        CH_AW = 2'd1,
        CH_W  = 2'd2,
        CH_R  = 2'd3
    } spy_chan_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAP  = 2'd2,
        OUT  = 2'd3
    } drain_state_e;

    // One-hot decode of a channel index into a pop strobe.
    function automatic logic [NUM_SPY_CH-1:0] chan_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/spy_rr_arb.sv
// Combinational 4-way round-robin arbiter with a priority subset.
// When any prio_req line is also requesting, only that subset competes;
// the search always starts one past last_grant.
module spy_rr_arb
    import axi_spy_pkg::*;
(
    input  logic [3:0] req,
    input  logic [3:0] prio_req,
    input  logic [1:0] last_grant,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);

    logic [3:0] cand;
    logic [1:0] idx;
    logic       found;

    // Pick the first candidate after last_grant, wrapping modulo 4.
    always_comb begin
        cand      = ((prio_req & req) != 4'b0000) ? (prio_req & req) : req;
        gnt_valid = (cand != 4'b0000);
        gnt_idx   = last_grant;
        idx       = '0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_SPY_CH; k++) begin
            idx = last_grant + 2'(k);
            if (!found && cand[idx]) begin
                gnt_idx = idx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_spy_drain_ctrl.sv
// Drains the four AXI spy FIFOs (AR, AW, W, R) onto one valid/ready stream.
// Each word goes POP -> CAP -> OUT; the FIFOs have a registered read port,
// so data is sampled one cycle after the pop strobe.
// Optional timestamp output enabled by defining SPY_DRAIN_TS_EN.
module axi_spy_drain_ctrl
    import axi_spy_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int TS_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    drain_en,
    input  logic [3:0]              chan_mask,
    input  logic [3:0]              ch_empty,
    input  logic [3:0]              ch_full,
    input  logic [4*WORD_WIDTH-1:0] ch_data,
    output logic [3:0]              ch_pop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_WIDTH-1:0]   out_data,
    output logic [1:0]              out_chan,
`ifdef SPY_DRAIN_TS_EN
    output logic [TS_WIDTH-1:0]     out_ts,
`endif
    output logic                    busy
);

    drain_state_e          state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            last_q, last_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic [1:0]            chan_q, chan_d;

    logic [3:0] elig;
    logic [1:0] arb_last;
    logic       gnt_valid;
    logic [1:0] gnt_idx;

    assign elig = {4{drain_en}} & chan_mask & ~ch_empty;

    // A handshake in OUT re-arbitrates in the same cycle, so the word being
    // retired already counts as the last grant.
    assign arb_last = (state_q == OUT && out_ready) ? grant_q : last_q;

    spy_rr_arb u_arb (
        .req        (elig),
        .prio_req   (elig & ch_full),
        .last_grant (arb_last),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // State and datapath registers; last grant resets to 3 so channel 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
            data_q  <= '0;
            chan_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    // Next state, grant registration and word capture.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        chan_d  = chan_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d = gnt_idx;
                    state_d = POP;
                end
            end
            POP: state_d = CAP;
            CAP: begin
                data_d  = ch_data[int'(grant_q)*WORD_WIDTH +: WORD_WIDTH];
                chan_d  = grant_q;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    last_d = grant_q;
                    if (gnt_valid) begin
                        grant_d = gnt_idx;
                        state_d = POP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        ch_pop    = (state_q == POP) ? chan_onehot(grant_q) : 4'b0000;
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
        out_data  = data_q;
        out_chan  = chan_q;
    end

`ifdef SPY_DRAIN_TS_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] out_ts_q;

    // Free-running timestamp, sampled alongside the data word in CAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q     <= '0;
            out_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (state_q == CAP) out_ts_q <= ts_q;
        end
    end

    assign out_ts = out_ts_q;
`else
    // No timestamp in this build; TS_WIDTH has nothing to size.
    if (TS_WIDTH == 0) begin : g_no_ts
    end
`endif

endmodule

// File: tb/tb_axi_spy_drain_ctrl.sv
// Bench for axi_spy_drain_ctrl: vector table for first-grant selection,
// directed multi-cycle sequences, then random traffic against a
// transaction-timeline reference model.
module tb_axi_spy_drain_ctrl;

    localparam int WW = 32;
    localparam int TW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            drain_en;
    logic [3:0]      chan_mask, ch_empty, ch_full;
    logic [4*WW-1:0] ch_data;
    logic [3:0]      ch_pop;
    logic            out_valid, out_ready;
    logic [WW-1:0]   out_data;
    logic [1:0]      out_chan;
    logic            busy;
`ifdef SPY_DRAIN_TS_EN
    logic [TW-1:0]   out_ts;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi_spy_drain_ctrl #(.WORD_WIDTH(WW), .TS_WIDTH(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .drain_en  (drain_en),
        .chan_mask (chan_mask),
        .ch_empty  (ch_empty),
        .ch_full   (ch_full),
        .ch_data   (ch_data),
        .ch_pop    (ch_pop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
`ifdef SPY_DRAIN_TS_EN
        .out_ts    (out_ts),
`endif
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data_cafe();
        for (int i = 0; i < 4; i++) ch_data[i*WW +: WW] = 32'hCAFE0000 + i;
    endtask

    // Hold reset for two edges, check reset values, release away from the edge.
    task automatic do_reset();
        reset     = 1'b0;
        drain_en  = 1'b1;
        chan_mask = 4'hF;
        ch_empty  = 4'hF;
        ch_full   = 4'h0;
        out_ready = 1'b1;
        set_data_cafe();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop",   ch_pop,    4'h0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_data",  out_data,  32'h0);
        chk("rst_chan",  out_chan,  2'd0);
        reset = 1'b1;
    endtask

    // Advance until a pop strobe appears or the budget runs out.
    task automatic wait_pop(input int lim, output logic [3:0] pop, output int dt);
        pop = 4'h0;
        dt  = 0;
        for (int i = 0; i < lim; i++) begin
            tick();
            dt++;
            if (ch_pop != 4'h0) begin
                pop = ch_pop;
                return;
            end
        end
    endtask

    // Reference rule: full channels compete first, round-robin after last.
    function automatic int pick(input logic [3:0] el, input logic [3:0] fu, input int last);
        logic [3:0] s;
        s = ((el & fu) != 4'h0) ? (el & fu) : el;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (s[c]) return c;
        end
        return -1;
    endfunction

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic [3:0] empty;
        logic [3:0] full;
        int         exp_ch;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [3:0] pop;
        int         dt;

        tbl[0] = '{1'b1, 4'hF, 4'b1011, 4'b0000, 2};
        tbl[1] = '{1'b1, 4'hF, 4'b0000, 4'b0000, 0};
        tbl[2] = '{1'b1, 4'hF, 4'b0000, 4'b1000, 3};
        tbl[3] = '{1'b1, 4'hF, 4'b0000, 4'b0110, 1};
        tbl[4] = '{1'b1, 4'b1110, 4'b0000, 4'b0000, 1};
        tbl[5] = '{1'b1, 4'b1110, 4'b0000, 4'b0001, 1};
        tbl[6] = '{1'b0, 4'hF, 4'b0000, 4'b1111, -1};
        tbl[7] = '{1'b1, 4'hF, 4'b1111, 4'b0000, -1};
        tbl[8] = '{1'b1, 4'hF, 4'b0011, 4'b1100, 2};

        // First grant after reset, latency 1 to pop and 3 to valid.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            drain_en  = tbl[v].en;
            chan_mask = tbl[v].mask;
            ch_empty  = tbl[v].empty;
            ch_full   = tbl[v].full;
            wait_pop(5, pop, dt);
            if (tbl[v].exp_ch < 0) begin
                chk($sformatf("tbl%0d_nopop", v), pop, 4'h0);
                chk($sformatf("tbl%0d_idle", v), busy, 1'b0);
            end else begin
                chk($sformatf("tbl%0d_pop", v), pop, 4'b1 << tbl[v].exp_ch);
                chk($sformatf("tbl%0d_dt", v), dt, 1);
                tick();
                chk($sformatf("tbl%0d_cap_novalid", v), out_valid, 1'b0);
                tick();
                chk($sformatf("tbl%0d_valid", v), out_valid, 1'b1);
                chk($sformatf("tbl%0d_data", v), out_data, 32'hCAFE0000 + tbl[v].exp_ch);
                chk($sformatf("tbl%0d_chan", v), out_chan, tbl[v].exp_ch);
            end
        end

        // Round-robin over all four channels, one pop every 3 cycles.
        do_reset();
        ch_empty = 4'h0;
        for (int k = 0; k < 5; k++) begin
            wait_pop(6, pop, dt);
            chk($sformatf("rr%0d_pop", k), pop, 4'b1 << (k % 4));
            chk($sformatf("rr%0d_dt", k), dt, (k == 0) ? 1 : 3);
        end

        // Full channel overtakes round-robin order after grant 0.
        do_reset();
        ch_empty = 4'h0;
        wait_pop(5, pop, dt);
        chk("full_first", pop, 4'b0001);
        ch_full = 4'b1000;
        wait_pop(6, pop, dt);
        chk("full_next", pop, 4'b1000);
        chk("full_dt", dt, 3);

        // Sink stall for 10 cycles in OUT, handshake in cycle 11.
        do_reset();
        out_ready = 1'b0;
        ch_empty  = 4'b1101;
        wait_pop(5, pop, dt);
        chk("stall_pop", pop, 4'b0010);
        tick();
        tick();
        chk("stall_valid1", out_valid, 1'b1);
        chk("stall_data1", out_data, 32'hCAFE0001);
        chk("stall_chan1", out_chan, 2'd1);
        ch_data = '0;
        for (int i = 2; i <= 10; i++) begin
            tick();
            chk($sformatf("stall%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("stall%0d_data", i), out_data, 32'hCAFE0001);
            chk($sformatf("stall%0d_chan", i), out_chan, 2'd1);
            chk($sformatf("stall%0d_pop", i), ch_pop, 4'h0);
        end
        tick();
        out_ready = 1'b1;
        chk("stall11_valid", out_valid, 1'b1);
        tick();
        chk("stall_next_pop", ch_pop, 4'b0010);
        chk("stall_drop_valid", out_valid, 1'b0);
        chk("stall_hold_data", out_data, 32'hCAFE0001);

        // Masked channel is never popped; drain_en low mid-word still delivers.
        do_reset();
        chan_mask = 4'b1110;
        ch_empty  = 4'b1110;
        pop = 4'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pop |= ch_pop;
        end
        chk("mask_nopop", pop, 4'h0);
        chk("mask_idle", busy, 1'b0);
        chan_mask = 4'hF;
        wait_pop(5, pop, dt);
        chk("den_pop", pop, 4'b0001);
        drain_en = 1'b0;
        tick();
        tick();
        chk("den_valid", out_valid, 1'b1);
        chk("den_data", out_data, 32'hCAFE0000);
        tick();
        chk("den_idle", busy, 1'b0);
        chk("den_novalid", out_valid, 1'b0);
        pop = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pop |= ch_pop;
        end
        chk("den_nopop", pop, 4'h0);

        // Asynchronous reset while the second word is in CAP.
        do_reset();
        ch_empty = 4'b1011;
        wait_pop(5, pop, dt);
        chk("arst_pop1", pop, 4'b0100);
        tick();
        tick();
        chk("arst_data1", out_data, 32'hCAFE0002);
        wait_pop(3, pop, dt);
        chk("arst_pop2", pop, 4'b0100);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pop",   ch_pop,    4'h0);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_busy",  busy,      1'b0);
        chk("arst_data",  out_data,  32'h0);
        chk("arst_chan",  out_chan,  2'd0);

        // Random traffic against a timeline model of each word's life.
        do_reset();
        begin
            bit         m_busy = 1'b0;
            int         m_last = 3;
            int         m_ch   = 0;
            int         m_pop_cyc = 0;
            logic [31:0] m_data = '0;
            logic [1:0]  m_chan = '0;
            logic [3:0]  exp_pop, el;
            bit          exp_valid;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(posedge clk);
                #1;
                drain_en  = ($urandom_range(0, 9) != 0);
                chan_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                ch_empty  = 4'($urandom);
                ch_full   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                out_ready = ($urandom_range(0, 9) < 7);
                for (int i = 0; i < 4; i++) ch_data[i*WW +: WW] = $urandom;
                #2;
                exp_pop   = (m_busy && cyc == m_pop_cyc) ? (4'b1 << m_ch) : 4'h0;
                exp_valid = m_busy && (cyc >= m_pop_cyc + 2);
                chk("rnd_pop",   ch_pop,    exp_pop);
                chk("rnd_valid", out_valid, exp_valid);
                chk("rnd_busy",  busy,      m_busy);
                chk("rnd_data",  out_data,  m_data);
                chk("rnd_chan",  out_chan,  m_chan);
                if (m_busy && cyc == m_pop_cyc + 1) begin
                    m_data = ch_data[m_ch*WW +: WW];
                    m_chan = 2'(m_ch);
                end
                if (exp_valid && out_ready) begin
                    m_last = m_ch;
                    m_busy = 1'b0;
                end
                if (!m_busy) begin
                    el = {4{drain_en}} & chan_mask & ~ch_empty;
                    if (el != 4'h0) begin
                        m_ch      = pick(el, ch_full, m_last);
                        m_pop_cyc = cyc + 1;
                        m_busy    = 1'b1;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
